mips_boot_loader: RTL and testbench
===================================

// Module: mips_boot_loader
// PURPOSE
//  Sequences the Mini MIPS CPU from a host word stream. The host sends headed command blocks.
//  The block writes instruction memory and data memory through the CPU's load port
//  (address / inst_data / write_instruction / write_data) while it holds the CPU in reset.
//  It then releases the CPU for a bounded or unbounded run and re-asserts CPU reset afterwards.
//  It sits between the host or testbench stream source and the CPU top level.
// PARAMETERS
//  ADDR_W  10  CPU memory address width; load addresses wrap modulo 2**ADDR_W
//  DATA_W  32  word width of the stream and of cpu_inst_data
//  CNT_W   16  width of the header count field (load words / run cycles)
// PORTS
//  clk              in   1       system clock, all logic on rising edge
//  rst              in   1       synchronous reset, active-low (0 = reset)
//  in_valid         in   1       host word valid
//  in_data          in   DATA_W  host word (header or payload)
//  in_ready         out  1       block accepts in_data this cycle
//  halt_req         in   1       host aborts an active run
//  cpu_rst          out  1       CPU reset, active-high (1 = CPU held)
//  cpu_address      out  ADDR_W  load address to CPU
//  cpu_inst_data    out  DATA_W  load data to CPU
//  cpu_write_instruction out 1   one-cycle instruction-memory write strobe
//  cpu_write_data   out  1       one-cycle data-memory write strobe
//  running          out  1       high while CPU is out of reset
//  done             out  1       one-cycle pulse when a run ends (budget expiry or halt)
//  err              out  1       sticky: unknown command received
// BEHAVIOUR
//  - Transfer occurs on in_valid & in_ready at a rising edge.
//  - Header fields: cmd=[31:30], start=[29:20], count=[CNT_W-1:0]. Bits [19:16] are ignored.
//  - cmd encoding: 01 = LOAD_INST, 10 = LOAD_DATA, 11 = RUN, 00 = illegal.
//  - States and transitions:
//    - IDLE: in_ready=1. On a header:
//      - 01 or 10 with count>0: latch start, count and target; go to LOAD.
//      - 01 or 10 with count==0: no-op, stay in IDLE.
//      - 11: go to RUN with budget = count (0 = unbounded).
//      - 00: set err, stay in IDLE.
//    - LOAD: in_ready=1. Each accepted payload word produces a write.
//      - Strobes are registered and appear in cycle N+1:
//        - cpu_address = current addr, cpu_inst_data = word;
//        - cpu_write_instruction (01) or cpu_write_data (10) high for exactly 1 cycle.
//      - Then addr = addr+1 mod 2**ADDR_W, remaining = remaining-1.
//      - Return to IDLE on the cycle the last word is accepted.
//      - Cycles with in_valid=0 produce no strobe and change no counters.
//    - RUN: in_ready=0, cpu_rst=0, running=1, starting the cycle after the header is accepted.
//      - The cycle counter decrements every cycle.
//      - For budget B>0, cpu_rst is low for exactly B cycles. Then cpu_rst=1, done pulses 1 cycle, go to IDLE.
//      - With budget 0, the run continues until halt_req.
//      - halt_req=1 in RUN: cpu_rst=1 the next cycle, done pulses, go to IDLE.
//      - halt_req wins if it coincides with budget expiry; done pulses once only.
//      - halt_req outside RUN is ignored.
//  - cpu_rst=1 at all times outside RUN, so writes only ever reach a held CPU.
//  - Write strobes are never both high. They are never high while cpu_rst=0.
//  - cpu_address and cpu_inst_data hold their last values when no strobe is active.
//  - Reset (rst=0), including mid-LOAD or mid-RUN:
//    - next state IDLE;
//    - cpu_rst=1, in_ready=0, all strobes 0, running=0, done=0, err=0;
//    - cpu_address=0, cpu_inst_data=0; counters cleared.
//    - A partially loaded block is abandoned and not resumed.
//    - in_ready rises the cycle after rst returns to 1.
// TESTING
//  1 Hold rst=0 for 3 cycles with in_valid=1 -> cpu_rst=1, in_ready=0, no strobes, err=0.
//  2 Send header 0x4000_0002, then words 0x2000_000A and 0x2006_000B back-to-back:
//    - instr strobes at addr 0 and 1 with those data, on consecutive cycles;
//    - cpu_write_data stays 0.
//  3 Send header 0xBFF0_0002, then words 5 and 6:
//    - data strobes at addr 1023 (data 5), then addr 0 (data 6), showing wrap-around.
//  4 Load 3 words with in_valid=0 gaps of 2 cycles between them:
//    - exactly 3 strobes at consecutive addresses;
//    - in_ready stays 1, then returns to IDLE.
//  5 Send header 0xC000_0005:
//    - cpu_rst=0 and running=1 for exactly 5 cycles;
//    - then done pulses once, cpu_rst=1 and in_ready=1;
//    - in_ready=0 during the run.
//  6 Two abort cases, then an illegal command:
//    - Header 0xC000_0000, pulse halt_req at run cycle 20 -> cpu_rst=1 next cycle, done pulses once.
//    - Drive rst=0 mid-LOAD -> outputs return to reset values; no further strobes.
//    - Then send header 0x0000_0001 -> err=1 (sticky) and the block stays in IDLE.

Source files
------------

// File: rtl/mips_boot_loader_if.sv
// Host stream, CPU load port and run-status signals of the Mini MIPS boot loader.
interface mips_boot_loader_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              halt_req;
    logic              cpu_rst;
    logic [ADDR_W-1:0] cpu_address;
    logic [DATA_W-1:0] cpu_inst_data;
    logic              cpu_write_instruction;
    logic              cpu_write_data;
    logic              running;
    logic              done;
    logic              err;

    // Host / stream-source side.
    modport master (
        output in_valid, in_data, halt_req,
        input  in_ready, cpu_rst, cpu_address, cpu_inst_data,
               cpu_write_instruction, cpu_write_data, running, done, err
    );

    // Boot loader side.
    modport slave (
        input  in_valid, in_data, halt_req,
        output in_ready, cpu_rst, cpu_address, cpu_inst_data,
               cpu_write_instruction, cpu_write_data, running, done, err
    );
endinterface

// File: rtl/mips_boot_loader.sv
// Mini MIPS boot loader: decodes host command blocks, loads instruction/data
// memory while the CPU is held in reset, then runs the CPU for a bounded or
// unbounded number of cycles.
module mips_boot_loader #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    mips_boot_loader_if.slave  bus
);
    localparam int unsigned CMD_LSB   = 30;
    localparam int unsigned START_LSB = 20;
    localparam int unsigned START_W   = 10;

    localparam logic [1:0] CMD_ILLEGAL   = 2'b00;
    localparam logic [1:0] CMD_LOAD_INST = 2'b01;
    localparam logic [1:0] CMD_LOAD_DATA = 2'b10;
    localparam logic [1:0] CMD_RUN       = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tgt_inst_q, tgt_inst_d;
    logic              unbounded_q, unbounded_d;

    logic              in_ready_q, in_ready_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic [ADDR_W-1:0] cpu_address_q, cpu_address_d;
    logic [DATA_W-1:0] cpu_inst_data_q, cpu_inst_data_d;
    logic              wr_inst_q, wr_inst_d;
    logic              wr_data_q, wr_data_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept_c;
    logic [1:0]        hdr_cmd_c;
    logic [ADDR_W-1:0] hdr_start_c;
    logic [CNT_W-1:0]  hdr_count_c;
    logic              unused_hdr_c;

    // Header field decode; bits [19:16] carry no meaning.
    assign accept_c     = bus.in_valid & in_ready_q;
    assign hdr_cmd_c    = bus.in_data[CMD_LSB +: 2];
    assign hdr_start_c  = ADDR_W'(bus.in_data[START_LSB +: START_W]);
    assign hdr_count_c  = bus.in_data[CNT_W-1:0];
    assign unused_hdr_c = ^bus.in_data;

    // Next-state and next-output logic.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        cnt_d           = cnt_q;
        tgt_inst_d      = tgt_inst_q;
        unbounded_d     = unbounded_q;
        cpu_address_d   = cpu_address_q;
        cpu_inst_data_d = cpu_inst_data_q;
        wr_inst_d       = 1'b0;
        wr_data_d       = 1'b0;
        done_d          = 1'b0;
        err_d           = err_q;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    case (hdr_cmd_c)
                        CMD_LOAD_INST, CMD_LOAD_DATA: begin
                            if (hdr_count_c != '0) begin
                                state_d    = S_LOAD;
                                addr_d     = hdr_start_c;
                                cnt_d      = hdr_count_c;
                                tgt_inst_d = (hdr_cmd_c == CMD_LOAD_INST);
                            end
                        end
                        CMD_RUN: begin
                            state_d     = S_RUN;
                            cnt_d       = hdr_count_c;
                            unbounded_d = (hdr_count_c == '0);
                        end
                        CMD_ILLEGAL: err_d = 1'b1;
                        default:     err_d = 1'b1;
                    endcase
                end
            end

            S_LOAD: begin
                if (accept_c) begin
                    cpu_address_d   = addr_q;
                    cpu_inst_data_d = bus.in_data;
                    wr_inst_d       = tgt_inst_q;
                    wr_data_d       = ~tgt_inst_q;
                    addr_d          = addr_q + ADDR_W'(1);
                    cnt_d           = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Halt and budget expiry end the run identically, so a
                // coincidence still yields a single done pulse.
                if (bus.halt_req || (!unbounded_q && cnt_q == CNT_W'(1))) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d != S_RUN);
        cpu_rst_d  = (state_d != S_RUN);
        running_d  = (state_d == S_RUN);
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            cnt_q           <= '0;
            tgt_inst_q      <= 1'b0;
            unbounded_q     <= 1'b0;
            in_ready_q      <= 1'b0;
            cpu_rst_q       <= 1'b1;
            cpu_address_q   <= '0;
            cpu_inst_data_q <= '0;
            wr_inst_q       <= 1'b0;
            wr_data_q       <= 1'b0;
            running_q       <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            cnt_q           <= cnt_d;
            tgt_inst_q      <= tgt_inst_d;
            unbounded_q     <= unbounded_d;
            in_ready_q      <= in_ready_d;
            cpu_rst_q       <= cpu_rst_d;
            cpu_address_q   <= cpu_address_d;
            cpu_inst_data_q <= cpu_inst_data_d;
            wr_inst_q       <= wr_inst_d;
            wr_data_q       <= wr_data_d;
            running_q       <= running_d;
            done_q          <= done_d;
            err_q           <= err_d;
        end
    end

    assign bus.in_ready              = in_ready_q;
    assign bus.cpu_rst               = cpu_rst_q;
    assign bus.cpu_address           = cpu_address_q;
    assign bus.cpu_inst_data         = cpu_inst_data_q;
    assign bus.cpu_write_instruction = wr_inst_q;
    assign bus.cpu_write_data        = wr_data_q;
    assign bus.running               = running_q;
    assign bus.done                  = done_q;
    assign bus.err                   = err_q;
endmodule

// File: tb/tb_mips_boot_loader.sv
// Self-checking bench for mips_boot_loader: load blocks from a vector table,
// write strobes checked against a scoreboard, hand-written run/abort/reset cases.
module tb_mips_boot_loader;
    logic clk = 1'b0;
    logic rst;

    mips_boot_loader_if bus ();

    mips_boot_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
        logic        inst;
        int unsigned c;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [31:0]       hdr;
        int unsigned       nw;
        logic              inst;
        int unsigned       gap;
        logic [2:0][31:0]  w;
        logic [2:0][9:0]   a;
    } load_vec_t;

    localparam int NV = 5;
    load_vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        chk("in_ready_at_send", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
    endtask

    function automatic load_vec_t mk(input logic [31:0] hdr, input int unsigned nw,
                                     input logic inst, input int unsigned gap,
                                     input logic [31:0] w0, input logic [31:0] w1,
                                     input logic [31:0] w2, input logic [9:0] a0,
                                     input logic [9:0] a1, input logic [9:0] a2);
        load_vec_t v;
        v.hdr = hdr; v.nw = nw; v.inst = inst; v.gap = gap;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2;
        return v;
    endfunction

    // Strobe monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.cpu_write_instruction || bus.cpu_write_data) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: actual addr=0x%0h data=0x%0h required none (t=%0t)",
                         bus.cpu_address, bus.cpu_inst_data, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("strobe_addr", 64'(bus.cpu_address), 64'(e.a));
                chk("strobe_data", 64'(bus.cpu_inst_data), 64'(e.d));
                chk("strobe_kind", 64'({bus.cpu_write_instruction, bus.cpu_write_data}),
                    e.inst ? 64'd2 : 64'd1);
                chk("strobe_cycle", 64'(cyc), 64'(e.c));
                chk("strobe_cpu_held", 64'(bus.cpu_rst), 64'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = mk(32'h4000_0002, 2, 1'b1, 0, 32'h2000_000A, 32'h2006_000B, 32'h0,
                     10'd0, 10'd1, 10'd0);
        vecs[1] = mk(32'hBFF0_0002, 2, 1'b0, 0, 32'h5, 32'h6, 32'h0,
                     10'd1023, 10'd0, 10'd0);
        vecs[2] = mk(32'h4640_0003, 3, 1'b1, 2, 32'h11, 32'h22, 32'h33,
                     10'd100, 10'd101, 10'd102);
        vecs[3] = mk(32'h8010_0000, 0, 1'b0, 0, 32'h0, 32'h0, 32'h0,
                     10'd0, 10'd0, 10'd0);
        vecs[4] = mk(32'h8000_0001, 1, 1'b0, 0, 32'hDEAD_BEEF, 32'h0, 32'h0,
                     10'd0, 10'd0, 10'd0);

        // Reset held with traffic present.
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h4000_0001;
        bus.halt_req = 1'b0;
        repeat (3) begin
            step();
            chk("rst_cpu_rst", 64'(bus.cpu_rst), 64'd1);
            chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
            chk("rst_strobes", 64'({bus.cpu_write_instruction, bus.cpu_write_data}), 64'd0);
            chk("rst_err", 64'(bus.err), 64'd0);
            chk("rst_running", 64'(bus.running), 64'd0);
            chk("rst_addr", 64'(bus.cpu_address), 64'd0);
        end
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        step();
        chk("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

        // Table-driven load blocks.
        for (int v = 0; v < NV; v++) begin
            send_word(vecs[v].hdr);
            for (int i = 0; i < int'(vecs[v].nw); i++) begin
                if (i > 0) begin
                    repeat (vecs[v].gap) begin
                        step();
                        chk("gap_in_ready", 64'(bus.in_ready), 64'd1);
                    end
                end
                sb.push_back('{vecs[v].a[i], vecs[v].w[i], vecs[v].inst, cyc + 1});
                send_word(vecs[v].w[i]);
            end
            step();
            step();
            chk("sb_drained", 64'(sb.size()), 64'd0);
            chk("load_in_ready", 64'(bus.in_ready), 64'd1);
            chk("load_err", 64'(bus.err), 64'd0);
            if (vecs[v].nw > 0) begin
                chk("addr_hold", 64'(bus.cpu_address), 64'(vecs[v].a[vecs[v].nw-1]));
                chk("data_hold", 64'(bus.cpu_inst_data), 64'(vecs[v].w[vecs[v].nw-1]));
            end
        end

        // Bounded run of 5 cycles.
        send_word(32'hC000_0005);
        for (int k = 0; k < 5; k++) begin
            chk("run_cpu_rst", 64'(bus.cpu_rst), 64'd0);
            chk("run_running", 64'(bus.running), 64'd1);
            chk("run_in_ready", 64'(bus.in_ready), 64'd0);
            chk("run_done", 64'(bus.done), 64'd0);
            step();
        end
        chk("end_cpu_rst", 64'(bus.cpu_rst), 64'd1);
        chk("end_done", 64'(bus.done), 64'd1);
        chk("end_in_ready", 64'(bus.in_ready), 64'd1);
        chk("end_running", 64'(bus.running), 64'd0);
        step();
        chk("end_done_once", 64'(bus.done), 64'd0);

        // Unbounded run aborted by halt_req at run cycle 20.
        send_word(32'hC000_0000);
        for (int k = 1; k < 20; k++) begin
            chk("unb_cpu_rst", 64'(bus.cpu_rst), 64'd0);
            step();
        end
        chk("unb_cycle20_running", 64'(bus.running), 64'd1);
        bus.halt_req = 1'b1;
        step();
        bus.halt_req = 1'b0;
        chk("halt_cpu_rst", 64'(bus.cpu_rst), 64'd1);
        chk("halt_done", 64'(bus.done), 64'd1);
        chk("halt_running", 64'(bus.running), 64'd0);
        step();
        chk("halt_done_once", 64'(bus.done), 64'd0);

        // halt_req outside a run has no effect.
        bus.halt_req = 1'b1;
        step();
        bus.halt_req = 1'b0;
        chk("idle_halt_done", 64'(bus.done), 64'd0);
        chk("idle_halt_cpu_rst", 64'(bus.cpu_rst), 64'd1);
        chk("idle_halt_in_ready", 64'(bus.in_ready), 64'd1);

        // halt_req coinciding with budget expiry: single done pulse.
        send_word(32'hC000_0003);
        step();
        step();
        chk("coin_last_cycle_cpu_rst", 64'(bus.cpu_rst), 64'd0);
        bus.halt_req = 1'b1;
        step();
        bus.halt_req = 1'b0;
        chk("coin_done", 64'(bus.done), 64'd1);
        chk("coin_cpu_rst", 64'(bus.cpu_rst), 64'd1);
        step();
        chk("coin_done_once", 64'(bus.done), 64'd0);

        // Reset in the middle of a 4-word load.
        send_word(32'h4000_0004);
        sb.push_back('{10'd0, 32'hA1, 1'b1, cyc + 1});
        send_word(32'hA1);
        sb.push_back('{10'd1, 32'hA2, 1'b1, cyc + 1});
        send_word(32'hA2);
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h3333;
        step();
        chk("midrst_cpu_rst", 64'(bus.cpu_rst), 64'd1);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("midrst_strobes", 64'({bus.cpu_write_instruction, bus.cpu_write_data}), 64'd0);
        chk("midrst_addr", 64'(bus.cpu_address), 64'd0);
        chk("midrst_data", 64'(bus.cpu_inst_data), 64'd0);
        chk("midrst_running", 64'(bus.running), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        step();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        step();
        chk("midrst_in_ready_back", 64'(bus.in_ready), 64'd1);
        send_word(32'h4000_0000);
        step();
        step();
        chk("midrst_sb_drained", 64'(sb.size()), 64'd0);
        chk("midrst_addr_still0", 64'(bus.cpu_address), 64'd0);

        // Illegal command sets sticky err and stays idle.
        send_word(32'h0000_0001);
        chk("illegal_err", 64'(bus.err), 64'd1);
        chk("illegal_in_ready", 64'(bus.in_ready), 64'd1);
        send_word(32'h8000_0000);
        chk("err_sticky", 64'(bus.err), 64'd1);
        sb.push_back('{10'd0, 32'h55, 1'b1, cyc + 2});
        send_word(32'h4000_0001);
        send_word(32'h55);
        step();
        step();
        chk("post_err_load_drained", 64'(sb.size()), 64'd0);
        chk("post_err_err", 64'(bus.err), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
